key_debounce_multi: RTL and testbench

N-channel key front end for the vending-machine panel: each channel synchronises a raw push-button input and debounces it with a stability counter. It then emits a clean level plus one-cycle press, release and long-press pulses, and optional auto-repeat pulses. It replaces per-key single-channel debouncers and feeds the coin/selection control FSM directly, with no extra edge detection downstream.

---
 rtl/key_debounce_multi.sv | 70 +++++++
 tb/tb_key_debounce_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel sync, debounce, press/release/long pulses; auto-repeat when KEY_REPEAT_EN is defined
module key_debounce_multi #(
  parameter int N = 4,
  parameter int DELAY = 2_500_000,
  parameter bit ACTIVE = 1'b1,
  parameter int LONG = 125_000_000,
  parameter int REPEAT = 25_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_lvl,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_rep
);
  localparam int DW = $clog2(DELAY);
  localparam int HW = $clog2(LONG + 1);
  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    logic s1, s2, lvl, press, rel, long_p, rep, raw_p, fl;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold;
    assign raw_p = s2 == ACTIVE;
    assign fl = raw_p != lvl && cnt == DW'(DELAY - 1);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1 <= ~ACTIVE;
        s2 <= ~ACTIVE;
        cnt <= '0;
        lvl <= 1'b0;
        press <= 1'b0;
        rel <= 1'b0;
        hold <= '0;
        long_p <= 1'b0;
      end else begin
        s1 <= key[i];
        s2 <= s1;
        cnt <= (raw_p == lvl || fl) ? '0 : cnt + 1'b1;
        lvl <= lvl ^ fl;
        press <= fl & ~lvl;
        rel <= fl & lvl;
        hold <= fl ? '0 : (lvl && hold != HW'(LONG)) ? hold + 1'b1 : hold;
        long_p <= lvl & ~fl & (hold == HW'(LONG - 1));
      end
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT + 1);
    logic [RW-1:0] rc;
    logic run;
    // hold parks at LONG once key_long has fired, which arms the repeat counter
    assign run = lvl & ~fl & (hold == HW'(LONG));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rc <= '0;
        rep <= 1'b0;
      end else begin
        rep <= run & (rc == RW'(REPEAT - 1));
        rc <= (!run || rc == RW'(REPEAT - 1)) ? '0 : rc + 1'b1;
      end
`else
    assign rep = 1'b0;
`endif
    assign key_lvl[i] = lvl;
    assign key_press[i] = press;
    assign key_release[i] = rel;
    assign key_long[i] = long_p;
    assign key_rep[i] = rep;
  end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed scenarios plus random key traffic checked against a window/timer reference model
module tb_key_debounce_multi;
  localparam int N = 4, DELAY = 4, LONG = 20, REPEAT = 5;
  localparam bit ACTIVE = 1'b1;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] key = '0;
  logic [N-1:0] key_lvl, key_press, key_release, key_long, key_rep;
  always #5 clk = ~clk;
  key_debounce_multi #(.N(N), .DELAY(DELAY), .ACTIVE(ACTIVE), .LONG(LONG), .REPEAT(REPEAT)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_lvl(key_lvl), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_rep(key_rep)
  );
  wire [5*N-1:0] dut_v = {key_lvl, key_press, key_release, key_long, key_rep};
  int cmp = 0, bad = 0;
  logic [DELAY:0] hist [N];
  logic [N-1:0] m_lvl, m_press, m_rel, m_long, m_rep;
  int since [N];
  function automatic logic [5*N-1:0] exp_v();
    return {m_lvl, m_press, m_rel, m_long, m_rep};
  endfunction
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      hist[c] = '0;
      since[c] = 0;
    end
    {m_lvl, m_press, m_rel, m_long, m_rep} = '0;
  endtask
  // the level flips once the last DELAY synchronised samples all disagree with it
  task automatic tick();
    logic [DELAY-1:0] win;
    logic fl, nl;
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int c = 0; c < N; c++) begin
      win = hist[c][DELAY:1];
      fl = m_lvl[c] ? (win == '0) : (&win);
      nl = m_lvl[c] ^ fl;
      m_press[c] = fl & !m_lvl[c];
      m_rel[c] = fl & m_lvl[c];
      if (m_press[c]) since[c] = 0;
      else if (m_lvl[c] && nl) since[c]++;
      m_long[c] = m_lvl[c] && nl && since[c] == LONG;
      m_rep[c] = REP_EN && m_lvl[c] && nl && since[c] > LONG && (since[c] - LONG) % REPEAT == 0;
      m_lvl[c] = nl;
      hist[c] = {hist[c][DELAY-1:0], key[c] == ACTIVE};
    end
    #1;
  endtask
  task automatic test_reset();
    model_reset();
    #1;
    cmp++;
    if (dut_v !== '0) begin bad++; $display("FAIL reset_async got=%h exp=0", dut_v); end
    repeat (3) tick();
    cmp++;
    if (dut_v !== '0) begin bad++; $display("FAIL reset_held got=%h exp=0", dut_v); end
    #2 rst_n = 1'b1;
    repeat (6) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, dut_v, exp_v()); end
    end
  endtask
  task automatic test_clean_press();
    key[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL clean_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      cmp++;
      if ({key_press[0], key_lvl[0], key_lvl[3:1]} !== {e == 6, e >= 6, 3'b000})
        begin bad++; $display("FAIL clean_press e=%0d press=%b lvl=%b exp_press=%b", e, key_press[0], key_lvl, e == 6); end
    end
    key[0] = 1'b0;
    repeat (10) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL clean_release got=%h exp=%h", dut_v, exp_v()); end
    end
  endtask
  task automatic test_bounce();
    for (int e = 1; e <= 16; e++) begin
      key[1] = (e != 4);
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL bounce_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      cmp++;
      if (key_press[1] !== (e == 10)) begin bad++; $display("FAIL bounce_press e=%0d got=%b exp=%b", e, key_press[1], e == 10); end
    end
    key[1] = 1'b0;
    repeat (10) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL bounce_release got=%h exp=%h", dut_v, exp_v()); end
    end
  endtask
  task automatic test_long_repeat();
    int pe = 0, le = 0, longs = 0, reps = 0, late = 0, rels = 0;
    key[2] = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL long_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      if (key_press[2]) pe = e;
      if (key_long[2]) begin le = e; longs++; end
      if (key_rep[2]) reps++;
    end
    cmp++;
    if (pe !== 6 || le !== 26 || longs !== 1)
      begin bad++; $display("FAIL long_timing press=%0d long=%0d count=%0d exp=6/26/1", pe, le, longs); end
    cmp++;
    if (reps !== (REP_EN ? 3 : 0)) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", reps, REP_EN ? 3 : 0); end
    key[2] = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL long_rel_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      if (key_release[2]) rels = e;
      if (e >= 6 && key_rep[2]) late++;
    end
    cmp++;
    if (rels !== 6 || late !== 0) begin bad++; $display("FAIL long_release rel=%0d late_reps=%0d exp=6/0", rels, late); end
  endtask
  task automatic test_short();
    int longs = 0, rels = 0;
    key[3] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 17) key[3] = 1'b0;
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL short_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      if (key_long[3]) longs++;
      if (key_release[3]) rels = e;
    end
    cmp++;
    if (longs !== 0 || rels !== 22) begin bad++; $display("FAIL short_press longs=%0d rel=%0d exp=0/22", longs, rels); end
  endtask
  task automatic test_reset_mid();
    int rels = 0;
    key[0] = 1'b1;
    repeat (8) tick();
    cmp++;
    if (key_lvl[0] !== 1'b1) begin bad++; $display("FAIL mid_pre lvl=%b exp=1", key_lvl[0]); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp++;
    if (dut_v !== '0) begin bad++; $display("FAIL mid_async got=%h exp=0", dut_v); end
    repeat (2) begin
      tick();
      if (key_release !== '0) rels++;
    end
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL mid_model e=%0d got=%h exp=%h", e, dut_v, exp_v()); end
      cmp++;
      if (key_press[0] !== (e == 6)) begin bad++; $display("FAIL mid_press e=%0d got=%b exp=%b", e, key_press[0], e == 6); end
      if (key_release !== '0) rels++;
    end
    cmp++;
    if (rels !== 0) begin bad++; $display("FAIL mid_release got=%0d exp=0", rels); end
    key[0] = 1'b0;
    repeat (12) tick();
  endtask
  task automatic test_random();
    int tmr [N];
    for (int c = 0; c < N; c++) tmr[c] = 1;
    for (int e = 0; e < 4000; e++) begin
      for (int c = 0; c < N; c++) begin
        tmr[c]--;
        if (tmr[c] == 0) begin
          key[c] = ~key[c];
          tmr[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp++;
        if (dut_v !== '0) begin bad++; $display("FAIL rand_reset t=%0t got=%h exp=0", $time, dut_v); end
        #2 rst_n = 1'b1;
      end
      tick();
      cmp++;
      if (dut_v !== exp_v()) begin bad++; $display("FAIL random t=%0t key=%b got=%h exp=%h", $time, key, dut_v, exp_v()); end
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_short();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
